// File: rtl/game_pkg.sv
// Shared screen/selection encodings and fixed RGB444 colours for the scene compositor.
package game_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    HOWTO = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef enum logic {
    SEL_START = 1'b0,
    SEL_HOWTO = 1'b1
  } sel_t;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_WHITE  = 12'hFFF;
  localparam logic [11:0] RGB_YELLOW = 12'hFF0;

endpackage

// File: rtl/frame_blink_timer.sv
// Detects frame start (vsync falling edge on the pixel strobe) and produces the menu blink phase.
module frame_blink_timer #(
  parameter int BLINK_PERIOD = 30
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pix_en,
  input  logic i_vsync_in,
  output logic o_frame_start,
  output logic o_blink_phase
);

  localparam int CW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  logic          r_vsync_prev;
  logic [CW-1:0] r_frame_cnt;
  logic          r_blink_phase;

  // Previous vsync is the last pix_en sample, so idle clocks never fake an edge.
  assign o_frame_start = i_pix_en & r_vsync_prev & ~i_vsync_in;
  assign o_blink_phase = r_blink_phase;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vsync_prev  <= 1'b1;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (i_pix_en) begin
      r_vsync_prev <= i_vsync_in;
      if (o_frame_start) begin
        if (r_frame_cnt == CW'(BLINK_PERIOD - 1)) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/scene_compositor.sv
// Game-screen FSM, menu cursor and per-screen text/background compositing onto registered VGA pins.
// Build option: define SCENE_COMPOSITOR_BLINK_EN to blink the selected menu item.
module scene_compositor
  import game_pkg::*;
#(
  parameter int          BLINK_PERIOD = 30,
  parameter logic [11:0] BG_MENU      = 12'h003,
  parameter logic [11:0] BG_OVER      = 12'h400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        start_text_on,
  input  logic        howto_text_on,
  input  logic        score_text_on,
  input  logic        hp_text_on,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_select,
  input  logic        game_over,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  game_state
);

  state_t      r_state, w_state_nxt;
  sel_t        r_sel, w_sel_nxt;
  state_t      r_disp_state;
  logic [11:0] r_rgb_p1;
  logic        r_hsync_p1, r_vsync_p1;
  logic [11:0] w_rgb_p0;
  logic        w_frame_start;
  logic        w_blink_phase;

  function automatic logic [11:0] pixel_colour(
    input state_t disp, input sel_t sel, input logic blink,
    input logic start_on, input logic howto_on, input logic score_on, input logic hp_on);
    logic sel_on, unsel_on;
    sel_on       = (sel == SEL_START) ? start_on : howto_on;
    unsel_on     = (sel == SEL_START) ? howto_on : start_on;
    pixel_colour = BG_MENU;
    case (disp)
      MENU: begin
        if (sel_on)        pixel_colour = blink ? RGB_YELLOW : BG_MENU;
        else if (unsel_on) pixel_colour = RGB_WHITE;
      end
      HOWTO:   pixel_colour = howto_on ? RGB_WHITE : BG_MENU;
      PLAY:    pixel_colour = (score_on | hp_on) ? RGB_WHITE : RGB_BLACK;
      default: pixel_colour = BG_OVER;
    endcase
  endfunction

`ifdef SCENE_COMPOSITOR_BLINK_EN
  frame_blink_timer #(
    .BLINK_PERIOD (BLINK_PERIOD)
  ) u_frame_blink_timer (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pix_en      (pix_en),
    .i_vsync_in    (vsync_in),
    .o_frame_start (w_frame_start),
    .o_blink_phase (w_blink_phase)
  );
`else
  // The registered vsync output already holds the previous pix_en sample.
  assign w_frame_start = pix_en & r_vsync_p1 & ~vsync_in;
  assign w_blink_phase = (BLINK_PERIOD >= 1);
`endif

  // Control: screen transitions run every clock; select acts on the pre-update cursor.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      MENU: begin
        if (btn_up && !btn_down)      w_sel_nxt = SEL_START;
        else if (btn_down && !btn_up) w_sel_nxt = SEL_HOWTO;
        if (btn_select) w_state_nxt = (r_sel == SEL_START) ? PLAY : HOWTO;
      end
      HOWTO: if (btn_select) w_state_nxt = MENU;
      PLAY:  if (game_over)  w_state_nxt = OVER;
      OVER: begin
        if (btn_select) begin
          w_state_nxt = MENU;
          w_sel_nxt   = SEL_START;
        end
      end
      default: w_state_nxt = MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MENU;
      r_sel   <= SEL_START;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign w_rgb_p0 = pixel_colour(r_disp_state, r_sel, w_blink_phase,
                                 start_text_on, howto_text_on, score_text_on, hp_text_on);

  // Pixel stage p0 -> p1: one pix_en of latency; displayed screen latches only at frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb_p1     <= '0;
      r_hsync_p1   <= 1'b1;
      r_vsync_p1   <= 1'b1;
      r_disp_state <= MENU;
    end else if (pix_en) begin
      r_rgb_p1   <= video_on ? w_rgb_p0 : RGB_BLACK;
      r_hsync_p1 <= hsync_in;
      r_vsync_p1 <= vsync_in;
      if (w_frame_start) r_disp_state <= r_state;
    end
  end

  assign rgb        = r_rgb_p1;
  assign hsync      = r_hsync_p1;
  assign vsync      = r_vsync_p1;
  assign game_state = r_state;

endmodule
